// File: rtl/ks_data_path_param.sv
// ks_data_path_param: parametrised K&S datapath (IR, regfile, PC, ALU, flags, decoder); KS_DP_XOR_EN adds XOR.
package ks_dp_pkg;
  typedef enum logic [4:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
`ifdef KS_DP_XOR_EN
    I_XOR,
`endif
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT
  } decoded_instruction_type;
endpackage

module ks_data_path_param
  import ks_dp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [2:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);
  localparam int RW = $clog2(NREGS);
`ifdef KS_DP_XOR_EN
  localparam bit xor_en = 1'b1;
`else
  localparam bit xor_en = 1'b0;
`endif

  if (DATA_W < 16 || NREGS < 2 || (1 << RW) != NREGS ||
      ADDR_W + RW > DATA_W - 8 || 3 * RW > DATA_W - 8) begin : g_bad_params
    $error("ks_data_path_param: illegal DATA_W/ADDR_W/NREGS combination");
  end

  logic [DATA_W-1:0] ir_q, pc_unused_pad;
  logic [ADDR_W-1:0] pc_q, mem_addr;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              zero_q, neg_q, uov_q, sov_q;
  logic [7:0]        opcode;
  decoded_instruction_type instr;
  logic              is_load, is_store, is_move, is_alu, is_br;
  logic [RW-1:0]     ls_f, f0, f1, f2, ra, rb, rc;
  logic [DATA_W-1:0] op_a, op_b, res;
  logic [DATA_W:0]   sum, dif;
  logic              uov, sov;
  logic              unused_ir;

  assign pc_unused_pad = '0;
  assign unused_ir = &{1'b0, ir_q, pc_unused_pad};
  assign opcode = ir_q[DATA_W-1 -: 8];

  always_comb begin
    instr = I_NOP;
    case (opcode)
      8'h81: instr = I_LOAD;
      8'h82: instr = I_STORE;
      8'h91: instr = I_MOVE;
      8'hA1: instr = I_ADD;
      8'hA2: instr = I_SUB;
      8'hA3: instr = I_AND;
      8'hA4: instr = I_OR;
`ifdef KS_DP_XOR_EN
      8'hA5: instr = I_XOR;
`endif
      8'h01: instr = I_BRANCH;
      8'h02: instr = I_BZERO;
      8'h03: instr = I_BNEG;
      8'h05: instr = I_BOV;
      8'h06: instr = I_BNOV;
      8'h0A: instr = I_BNNEG;
      8'h0B: instr = I_BNZERO;
      8'hFF: instr = I_HALT;
      default: instr = I_NOP;
    endcase
  end

  // ALU and branch groups share an opcode nibble, so a non-NOP decode identifies the group
  assign is_load  = instr == I_LOAD;
  assign is_store = instr == I_STORE;
  assign is_move  = instr == I_MOVE;
  assign is_alu   = opcode[7:4] == 4'hA && instr != I_NOP;
  assign is_br    = opcode[7:4] == 4'h0 && instr != I_NOP;

  assign ls_f = ir_q[ADDR_W+RW-1:ADDR_W];
  assign f0   = ir_q[RW-1:0];
  assign f1   = ir_q[2*RW-1:RW];
  assign f2   = ir_q[3*RW-1:2*RW];

  assign mem_addr = (is_load || is_store || is_br) ? ir_q[ADDR_W-1:0] : '0;
  assign ra = is_store ? ls_f : is_move ? f0 : is_alu ? f1 : '0;
  assign rb = (is_move || is_alu) ? f0 : '0;
  assign rc = is_load ? ls_f : is_move ? f1 : is_alu ? f2 : '0;

  assign op_a = regs_q[ra];
  assign op_b = regs_q[rb];

  assign sum = {1'b0, op_a} + {1'b0, op_b};
  assign dif = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    res = operation == 3'd0 ? sum[DATA_W-1:0] :
          operation == 3'd1 ? dif[DATA_W-1:0] :
          operation == 3'd2 ? op_a & op_b :
          operation == 3'd3 ? op_a | op_b :
          (xor_en && operation == 3'd4) ? op_a ^ op_b : op_a;
    uov = operation == 3'd0 ? sum[DATA_W] : operation == 3'd1 ? dif[DATA_W] : 1'b0;
    sov = operation == 3'd0 ? (op_a[DATA_W-1] == op_b[DATA_W-1]) && (res[DATA_W-1] != op_a[DATA_W-1]) :
          operation == 3'd1 ? (op_a[DATA_W-1] != op_b[DATA_W-1]) && (res[DATA_W-1] != op_a[DATA_W-1]) :
          1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= '0;
      pc_q <= '0;
      {zero_q, neg_q, uov_q, sov_q} <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (ir_enable) ir_q <= data_in;
      if (pc_enable) pc_q <= branch ? mem_addr : pc_q + ADDR_W'(1);
      if (write_reg_enable) regs_q[rc] <= c_sel ? data_in : res;
      if (flags_reg_enable) {zero_q, neg_q, uov_q, sov_q} <= {res == '0, res[DATA_W-1], uov, sov};
    end
  end

  assign decoded_instruction = instr;
  assign ram_addr            = addr_sel ? mem_addr : pc_q;
  assign data_out            = op_a;
  assign zero_op             = zero_q;
  assign neg_op              = neg_q;
  assign unsigned_overflow   = uov_q;
  assign signed_overflow     = sov_q;
endmodule

// File: tb/tb_ks_data_path_param.sv
// tb_ks_data_path_param: randomized and directed checks of ks_data_path_param against an arithmetic model.
module tb_ks_data_path_param;
  import ks_dp_pkg::*;
  localparam int W = 16, AW = 5, N = 4;

  logic clk = 1'b0;
  logic rst, branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable;
  logic [2:0] operation;
  logic [W-1:0] data_in, data_out;
  logic [AW-1:0] ram_addr;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;

  int errs = 0, checks = 0;
  logic [W-1:0] m_r [N];
  logic [AW-1:0] m_pc;
  logic [W-1:0] m_ir;
  logic m_z, m_n, m_u, m_s;
  bit m_valid = 0;

  always #5 clk = ~clk;

  ks_data_path_param dut (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .decoded_instruction(decoded_instruction), .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .ram_addr(ram_addr), .data_out(data_out), .data_in(data_in)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void decode(input logic [W-1:0] ir, output decoded_instruction_type ins,
                                 output int a, output int b, output int c, output int ma);
    int v, op, ls, f0, f1, f2, adr;
    v = int'(ir);
    op = v / 256;
    ls = (v >> AW) % N;
    f0 = v % N;
    f1 = (v / N) % N;
    f2 = (v / (N * N)) % N;
    adr = v % (1 << AW);
    ins = I_NOP; a = 0; b = 0; c = 0; ma = 0;
    case (op)
      'h81: begin ins = I_LOAD; c = ls; ma = adr; end
      'h82: begin ins = I_STORE; a = ls; ma = adr; end
      'h91: begin ins = I_MOVE; c = f1; a = f0; b = f0; end
      'hA1: begin ins = I_ADD; c = f2; a = f1; b = f0; end
      'hA2: begin ins = I_SUB; c = f2; a = f1; b = f0; end
      'hA3: begin ins = I_AND; c = f2; a = f1; b = f0; end
      'hA4: begin ins = I_OR; c = f2; a = f1; b = f0; end
`ifdef KS_DP_XOR_EN
      'hA5: begin ins = I_XOR; c = f2; a = f1; b = f0; end
`endif
      'h01: begin ins = I_BRANCH; ma = adr; end
      'h02: begin ins = I_BZERO; ma = adr; end
      'h03: begin ins = I_BNEG; ma = adr; end
      'h05: begin ins = I_BOV; ma = adr; end
      'h06: begin ins = I_BNOV; ma = adr; end
      'h0A: begin ins = I_BNNEG; ma = adr; end
      'h0B: begin ins = I_BNZERO; ma = adr; end
      'hFF: ins = I_HALT;
      default: ins = I_NOP;
    endcase
  endfunction

  function automatic void alu(input logic [2:0] op, input logic [W-1:0] A, input logic [W-1:0] B,
                              output logic [W-1:0] res, output logic u, output logic s);
    longint ua, ub, sa, sb, t, smax, smin;
    ua = A; ub = B; sa = $signed(A); sb = $signed(B);
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    u = 0; s = 0; res = A;
    if (op == 0) begin
      t = ua + ub; res = W'(t); u = t >= (longint'(1) << W);
      s = (sa + sb > smax) || (sa + sb < smin);
    end else if (op == 1) begin
      t = ua - ub; res = W'(t); u = ua < ub;
      s = (sa - sb > smax) || (sa - sb < smin);
    end else if (op == 2) res = A & B;
    else if (op == 3) res = A | B;
`ifdef KS_DP_XOR_EN
    else if (op == 4) res = A ^ B;
`endif
  endfunction

  task automatic tick();
    decoded_instruction_type ins;
    int a, b, c, ma;
    logic [W-1:0] A, B, res;
    logic u, s;
    #1;
    decode(m_ir, ins, a, b, c, ma);
    A = m_r[a]; B = m_r[b];
    alu(operation, A, B, res, u, s);
    if (m_valid) begin
      chk("decode", decoded_instruction, ins);
      chk("ram_addr", ram_addr, addr_sel ? AW'(ma) : m_pc);
      chk("data_out", data_out, A);
      chk("flags", {zero_op, neg_op, unsigned_overflow, signed_overflow}, {m_z, m_n, m_u, m_s});
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) m_r[i] = '0;
      m_pc = '0; m_ir = '0; {m_z, m_n, m_u, m_s} = '0; m_valid = 1;
    end else begin
      if (write_reg_enable) m_r[c] = c_sel ? data_in : res;
      if (flags_reg_enable) begin m_z = res == 0; m_n = res[W-1]; m_u = u; m_s = s; end
      if (pc_enable) m_pc = branch ? AW'(ma) : AW'((int'(m_pc) + 1) % (1 << AW));
      if (ir_enable) m_ir = data_in;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
    operation = 3'd0; write_reg_enable = 0; flags_reg_enable = 0; data_in = '0;
  endtask

  task automatic load_ir(input logic [W-1:0] v);
    idle(); ir_enable = 1; data_in = v; tick(); idle();
  endtask

  task automatic load_reg(input int r, input logic [W-1:0] v);
    load_ir(16'h8100 | W'(r << AW));
    c_sel = 1; write_reg_enable = 1; data_in = v; tick(); idle();
  endtask

  task automatic read_reg(input string name, input int r, input logic [W-1:0] exp);
    load_ir(16'h8200 | W'(r << AW));
    #1 chk(name, data_out, exp);
  endtask

  task automatic alu_op(input logic [2:0] op);
    load_ir(16'hA136);
    operation = op; write_reg_enable = 1; flags_reg_enable = 1; tick(); idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [20] = '{8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h01, 8'h02,
                             8'h03, 8'h05, 8'h06, 8'h0A, 8'h0B, 8'hFF, 8'h00, 8'h7F, 8'h91, 8'hA1};
    idle(); rst = 1; tick(); idle();
    #1;
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_flags", {zero_op, neg_op, unsigned_overflow, signed_overflow}, 0);
    chk("rst_decode", decoded_instruction, I_NOP);
    for (int r = 0; r < N; r++) read_reg($sformatf("rst_R%0d", r), r, 16'h0000);

    load_ir(16'h8127);
    addr_sel = 1; c_sel = 1; data_in = 16'h1234; write_reg_enable = 1;
    #1;
    chk("load_ram_addr", ram_addr, 7);
    chk("load_decode", decoded_instruction, I_LOAD);
    tick(); idle();
    read_reg("load_R1", 1, 16'h1234);

    load_reg(1, 16'h7FFF); load_reg(2, 16'h0001); alu_op(3'd0);
    chk("add_flags", {zero_op, neg_op, unsigned_overflow, signed_overflow}, 4'b0101);
    read_reg("add_R3", 3, 16'h8000);

    load_reg(1, 16'h0001); load_reg(2, 16'h0002); alu_op(3'd1);
    chk("sub_flags", {zero_op, neg_op, unsigned_overflow, signed_overflow}, 4'b0110);
    read_reg("sub_R3", 3, 16'hFFFF);
    load_reg(1, 16'h0005); load_reg(2, 16'h0005); alu_op(3'd1);
    chk("sub_zero_flags", {zero_op, neg_op, unsigned_overflow, signed_overflow}, 4'b1000);

    load_reg(1, 16'hF0F0); load_reg(2, 16'hFF00); alu_op(3'd4);
`ifdef KS_DP_XOR_EN
    read_reg("xor_R3", 3, 16'h0FF0);
    load_ir(16'hA500); #1 chk("xor_decode", decoded_instruction, I_XOR);
`else
    read_reg("xor_R3", 3, 16'hF0F0);
    load_ir(16'hA500); #1 chk("xor_decode", decoded_instruction, I_NOP);
`endif

    idle(); pc_enable = 1;
    repeat (31) tick();
    idle(); #1 chk("pc_31", ram_addr, 31);
    pc_enable = 1; tick(); idle();
    #1 chk("pc_wrap", ram_addr, 0);
    load_ir(16'h0109);
    #1 chk("br_decode", decoded_instruction, I_BRANCH);
    pc_enable = 1; branch = 1; tick(); idle();
    #1 chk("pc_branch", ram_addr, 9);
    rst = 1; pc_enable = 1; tick(); idle();
    #1;
    chk("pc_rst", ram_addr, 0);
    chk("rst_decode2", decoded_instruction, I_NOP);

    repeat (3000) begin
      rst = $urandom_range(0, 99) == 0;
      branch = 1'($urandom_range(0, 1));
      pc_enable = 1'($urandom_range(0, 1));
      ir_enable = 1'($urandom_range(0, 1));
      addr_sel = 1'($urandom_range(0, 1));
      c_sel = 1'($urandom_range(0, 1));
      operation = 3'($urandom_range(0, 7));
      write_reg_enable = 1'($urandom_range(0, 1));
      flags_reg_enable = 1'($urandom_range(0, 1));
      data_in = $urandom_range(0, 1) ? {ops[$urandom_range(0, 19)], 8'($urandom)} : 16'($urandom);
      tick();
    end
    idle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
